// File: rtl/display_n_digitos_pkg.sv
// Shared seven-segment patterns (active-low, a..g from bit 6 to bit 0)
// and the converter FSM state encoding.
package display_n_digitos_pkg;

    localparam logic [6:0] SEG_0       = 7'b0000001;
    localparam logic [6:0] SEG_1       = 7'b1001111;
    localparam logic [6:0] SEG_2       = 7'b0010010;
    localparam logic [6:0] SEG_3       = 7'b0000110;
    localparam logic [6:0] SEG_4       = 7'b1001100;
    localparam logic [6:0] SEG_5       = 7'b0100100;
    localparam logic [6:0] SEG_6       = 7'b0100000;
    localparam logic [6:0] SEG_7       = 7'b0001111;
    localparam logic [6:0] SEG_8       = 7'b0000000;
    localparam logic [6:0] SEG_9       = 7'b0000100;
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;
    localparam logic [6:0] SEG_TRACO   = 7'b1111110;

    typedef enum logic {
        OCIOSO   = 1'b0,
        CONVERTE = 1'b1
    } estado_t;

    // Non-decimal codes map to dash so a corrupted digit is never shown as a number.
    function automatic logic [6:0] seg_digito(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_TRACO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd7seg_dec.sv
// Combinational BCD digit to seven-segment decoder with dash and blank overrides;
// dash takes priority over blank.
module bcd7seg_dec
    import display_n_digitos_pkg::*;
(
    input  logic [3:0] digito_i,
    input  logic       apaga_i,
    input  logic       traco_i,
    output logic [6:0] seg_o
);

    // Select the displayed pattern for one digit.
    always_comb begin
        seg_o = SEG_APAGADO;
        if (traco_i) begin
            seg_o = SEG_TRACO;
        end else if (apaga_i) begin
            seg_o = SEG_APAGADO;
        end else begin
            seg_o = seg_digito(digito_i);
        end
    end

endmodule

// File: rtl/display_n_digitos.sv
// Sequential binary-to-BCD converter (shift-and-add-3) driving DIGITOS
// seven-segment digits, with overflow dash display and leading-zero blanking.
module display_n_digitos
    import display_n_digitos_pkg::*;
#(
    parameter int LARGURA     = 32,
    parameter int DIGITOS     = 4,
    parameter int APAGA_ZEROS = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [LARGURA-1:0]     valor,
    output logic [7*DIGITOS-1:0]   segmentos,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int BCD_W  = 4 * DIGITOS;
    localparam int SEG_W  = 7 * DIGITOS;
    localparam int CONT_W = 6;
    localparam logic [CONT_W-1:0] CONT_UM    = CONT_W'(1);
    localparam logic [CONT_W-1:0] CONT_CARGA = CONT_W'(LARGURA);

    estado_t             estado_q, estado_d;
    logic [LARGURA-1:0]  desloc_q, desloc_d;
    logic [BCD_W-1:0]    acum_q, acum_d;
    logic                carry_q, carry_d;
    logic [CONT_W-1:0]   cont_q, cont_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [BCD_W-1:0]    acum_aj_s;
    logic [BCD_W-1:0]    acum_sh_s;
    logic                carry_fim_s;
    logic [DIGITOS-1:0]  apaga_s;
    logic                nz_s;
    logic [SEG_W-1:0]    seg_dec_s;

    // Add-3 correction on every digit that would reach 10 or more after doubling.
    always_comb begin
        acum_aj_s = acum_q;
        for (int i = 0; i < DIGITOS; i++) begin
            if (acum_q[4*i +: 4] >= 4'd5) begin
                acum_aj_s[4*i +: 4] = acum_q[4*i +: 4] + 4'd3;
            end else begin
                acum_aj_s[4*i +: 4] = acum_q[4*i +: 4];
            end
        end
    end

    assign acum_sh_s   = {acum_aj_s[BCD_W-2:0], desloc_q[LARGURA-1]};
    assign carry_fim_s = carry_q | acum_aj_s[BCD_W-1];

    // Blank zero digits above the most significant nonzero one; digit 0 is never blanked.
    always_comb begin
        apaga_s = {DIGITOS{1'b0}};
        nz_s    = 1'b0;
        for (int i = DIGITOS - 1; i >= 1; i--) begin
            nz_s       = nz_s | (acum_sh_s[4*i +: 4] != 4'd0);
            apaga_s[i] = (APAGA_ZEROS != 0) && !nz_s;
        end
    end

    for (genvar g = 0; g < DIGITOS; g++) begin : g_dec
        bcd7seg_dec u_dec (
            .digito_i (acum_sh_s[4*g +: 4]),
            .apaga_i  (apaga_s[g]),
            .traco_i  (carry_fim_s),
            .seg_o    (seg_dec_s[7*g +: 7])
        );
    end

    // Next-state logic: idle capture, per-cycle shift, result load on the final shift.
    always_comb begin
        estado_d = estado_q;
        desloc_d = desloc_q;
        acum_d   = acum_q;
        carry_d  = carry_q;
        cont_d   = cont_q;
        bcd_d    = bcd_q;
        seg_d    = seg_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    desloc_d = valor;
                    acum_d   = {BCD_W{1'b0}};
                    carry_d  = 1'b0;
                    cont_d   = CONT_CARGA;
                    busy_d   = 1'b1;
                    estado_d = CONVERTE;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            CONVERTE: begin
                desloc_d = {desloc_q[LARGURA-2:0], 1'b0};
                acum_d   = acum_sh_s;
                carry_d  = carry_fim_s;
                cont_d   = cont_q - CONT_UM;
                if (cont_q == CONT_UM) begin
                    bcd_d    = carry_fim_s ? {BCD_W{1'b1}} : acum_sh_s;
                    seg_d    = seg_dec_s;
                    ovf_d    = carry_fim_s;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    estado_d = OCIOSO;
                end else begin
                    busy_d   = 1'b1;
                end
            end
            default: begin
                busy_d   = 1'b0;
                estado_d = OCIOSO;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= OCIOSO;
            desloc_q <= {LARGURA{1'b0}};
            acum_q   <= {BCD_W{1'b0}};
            carry_q  <= 1'b0;
            cont_q   <= {CONT_W{1'b0}};
            bcd_q    <= {BCD_W{1'b0}};
            seg_q    <= {DIGITOS{SEG_APAGADO}};
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            desloc_q <= desloc_d;
            acum_q   <= acum_d;
            carry_q  <= carry_d;
            cont_q   <= cont_d;
            bcd_q    <= bcd_d;
            seg_q    <= seg_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign segmentos = seg_q;
    assign bcd       = bcd_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_display_n_digitos.sv
// Directed self-checking bench for display_n_digitos: default, no-blanking
// and 8-bit/3-digit configurations.
module tb_display_n_digitos;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b1111110;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        start = 1'b0;
    logic [31:0] valor = 32'd0;
    logic [27:0] segmentos;
    logic [15:0] bcd;
    logic        busy, done, overflow;

    logic        start_nz = 1'b0;
    logic [31:0] valor_nz = 32'd0;
    logic [27:0] segmentos_nz;
    logic [15:0] bcd_nz;
    logic        busy_nz, done_nz, overflow_nz;

    logic        start8 = 1'b0;
    logic [7:0]  valor8 = 8'd0;
    logic [20:0] segmentos8;
    logic [11:0] bcd8;
    logic        busy8, done8, overflow8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    display_n_digitos dut (
        .clock(clock), .reset_n(reset_n), .start(start), .valor(valor),
        .segmentos(segmentos), .bcd(bcd), .busy(busy), .done(done), .overflow(overflow)
    );

    display_n_digitos #(.LARGURA(32), .DIGITOS(4), .APAGA_ZEROS(0)) dut_nz (
        .clock(clock), .reset_n(reset_n), .start(start_nz), .valor(valor_nz),
        .segmentos(segmentos_nz), .bcd(bcd_nz), .busy(busy_nz), .done(done_nz),
        .overflow(overflow_nz)
    );

    display_n_digitos #(.LARGURA(8), .DIGITOS(3), .APAGA_ZEROS(1)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .valor(valor8),
        .segmentos(segmentos8), .bcd(bcd8), .busy(busy8), .done(done8),
        .overflow(overflow8)
    );

    // Called at a negedge: pulses start for one cycle and counts edges until done.
    task automatic lanca(input logic [31:0] v, output int lat);
        start = 1'b1;
        valor = v;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        if ({busy, done, overflow} !== 3'b000) begin
            $display("FAIL reset_flags: got %b want 000", {busy, done, overflow}); n_err++;
        end
        n_cmp++;
        if (bcd !== 16'h0000) begin
            $display("FAIL reset_bcd: got %h want 0000", bcd); n_err++;
        end
        n_cmp++;
        if (segmentos !== {SB, SB, SB, SB}) begin
            $display("FAIL reset_seg: got %b want all blank", segmentos); n_err++;
        end
        n_cmp++;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic;
        int lat;
        @(negedge clock);
        start = 1'b1;
        valor = 32'd1234;
        @(negedge clock);
        start = 1'b0;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy: got %b want 1", busy); n_err++;
        end
        n_cmp++;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (lat !== 32) begin
            $display("FAIL basic_latency: got %0d want 32", lat); n_err++;
        end
        n_cmp++;
        if (bcd !== 16'h1234) begin
            $display("FAIL basic_bcd: got %h want 1234", bcd); n_err++;
        end
        n_cmp++;
        if (segmentos !== {S1, S2, S3, S4}) begin
            $display("FAIL basic_seg: got %b want %b", segmentos, {S1, S2, S3, S4}); n_err++;
        end
        n_cmp++;
        if ({busy, overflow} !== 2'b00) begin
            $display("FAIL basic_busy_ovf: got %b want 00", {busy, overflow}); n_err++;
        end
        n_cmp++;
        repeat (3) @(negedge clock);
        if (done !== 1'b0 || bcd !== 16'h1234) begin
            $display("FAIL basic_hold: got done=%b bcd=%h want done=0 bcd=1234", done, bcd); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_limits;
        int lat;
        @(negedge clock);
        lanca(32'd9999, lat);
        if (lat !== 32 || overflow !== 1'b0 || bcd !== 16'h9999) begin
            $display("FAIL lim_9999: got lat=%0d ovf=%b bcd=%h want 32 0 9999", lat, overflow, bcd); n_err++;
        end
        n_cmp++;
        if (segmentos !== {S9, S9, S9, S9}) begin
            $display("FAIL lim_9999_seg: got %b want all 9", segmentos); n_err++;
        end
        n_cmp++;
        @(negedge clock);
        lanca(32'd10000, lat);
        if (overflow !== 1'b1 || bcd !== 16'hFFFF) begin
            $display("FAIL lim_10000: got ovf=%b bcd=%h want 1 ffff", overflow, bcd); n_err++;
        end
        n_cmp++;
        if (segmentos !== {SD, SD, SD, SD}) begin
            $display("FAIL lim_10000_seg: got %b want all dash", segmentos); n_err++;
        end
        n_cmp++;
        @(negedge clock);
        lanca(32'hFFFF_FFFF, lat);
        if (overflow !== 1'b1 || bcd !== 16'hFFFF) begin
            $display("FAIL lim_max: got ovf=%b bcd=%h want 1 ffff", overflow, bcd); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_zero;
        @(negedge clock);
        start = 1'b1; valor = 32'd0;
        start_nz = 1'b1; valor_nz = 32'd0;
        @(negedge clock);
        start = 1'b0; start_nz = 1'b0;
        repeat (32) @(negedge clock);
        if (done !== 1'b1 || done_nz !== 1'b1) begin
            $display("FAIL zero_done: got %b%b want 11", done, done_nz); n_err++;
        end
        n_cmp++;
        if (segmentos !== {SB, SB, SB, S0} || bcd !== 16'h0000 || overflow !== 1'b0) begin
            $display("FAIL zero_blank: got seg=%b bcd=%h ovf=%b", segmentos, bcd, overflow); n_err++;
        end
        n_cmp++;
        if (segmentos_nz !== {S0, S0, S0, S0} || bcd_nz !== 16'h0000 || overflow_nz !== 1'b0) begin
            $display("FAIL zero_noblank: got seg=%b bcd=%h ovf=%b", segmentos_nz, bcd_nz, overflow_nz); n_err++;
        end
        n_cmp++;
        if (busy_nz !== 1'b0) begin
            $display("FAIL zero_busy_nz: got %b want 0", busy_nz); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_ignore_start;
        int dones;
        int lat;
        dones = 0;
        lat = 0;
        @(negedge clock);
        start = 1'b1;
        valor = 32'd5678;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (done) begin
                dones++;
                lat = k;
            end
            start = (k == 5 || k == 10);
            if (k == 5) valor = 32'd1111;
        end
        if (dones !== 1 || lat !== 32) begin
            $display("FAIL ignore_dones: got %0d pulses lat=%0d want 1 pulse lat=32", dones, lat); n_err++;
        end
        n_cmp++;
        if (bcd !== 16'h5678) begin
            $display("FAIL ignore_bcd: got %h want 5678", bcd); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clock);
        lanca(32'd1234, lat);
        lanca(32'd4321, lat);
        if (lat !== 32 || bcd !== 16'h4321) begin
            $display("FAIL b2b_second: got lat=%0d bcd=%h want 32 4321", lat, bcd); n_err++;
        end
        n_cmp++;
        if (segmentos !== {S4, S3, S2, S1}) begin
            $display("FAIL b2b_seg: got %b want %b", segmentos, {S4, S3, S2, S1}); n_err++;
        end
        n_cmp++;
        @(negedge clock);
        if (done !== 1'b0) begin
            $display("FAIL b2b_pulse_width: got %b want 0", done); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid;
        int dones;
        int lat;
        dones = 0;
        @(negedge clock);
        start = 1'b1;
        valor = 32'd5678;
        @(negedge clock);
        start = 1'b0;
        repeat (11) @(negedge clock);
        reset_n = 1'b0;
        #1;
        if ({busy, done, overflow} !== 3'b000 || bcd !== 16'h0000 || segmentos !== {SB, SB, SB, SB}) begin
            $display("FAIL rstmid_during: got flags=%b bcd=%h seg=%b", {busy, done, overflow}, bcd, segmentos); n_err++;
        end
        n_cmp++;
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done) dones++;
        end
        if (dones !== 0 || segmentos !== {SB, SB, SB, SB} || bcd !== 16'h0000) begin
            $display("FAIL rstmid_abort: got dones=%0d bcd=%h seg=%b", dones, bcd, segmentos); n_err++;
        end
        n_cmp++;
        lanca(32'd42, lat);
        if (lat !== 32 || bcd !== 16'h0042) begin
            $display("FAIL rstmid_42: got lat=%0d bcd=%h want 32 0042", lat, bcd); n_err++;
        end
        n_cmp++;
        if (segmentos !== {SB, SB, S4, S2}) begin
            $display("FAIL rstmid_42_seg: got %b want %b", segmentos, {SB, SB, S4, S2}); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_small;
        int lat;
        @(negedge clock);
        start8 = 1'b1;
        valor8 = 8'd255;
        @(negedge clock);
        start8 = 1'b0;
        if (busy8 !== 1'b1) begin
            $display("FAIL small_busy: got %b want 1", busy8); n_err++;
        end
        n_cmp++;
        lat = 0;
        while (!done8 && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        if (lat !== 8 || bcd8 !== 12'h255 || overflow8 !== 1'b0) begin
            $display("FAIL small_255: got lat=%0d bcd=%h ovf=%b want 8 255 0", lat, bcd8, overflow8); n_err++;
        end
        n_cmp++;
        if (segmentos8 !== {S2, S5, S5}) begin
            $display("FAIL small_seg: got %b want %b", segmentos8, {S2, S5, S5}); n_err++;
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_limits();
        test_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
